fsm_input_arbiter: RTL
======================

FSM_INPUT_ARBITER -- requirements
Module: fsm_input_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 4, max consecutive granted cycles while the other requester waits; legal range 1..7.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0, req1  input  1 each  request from requester 0/1 for the shared 2-input FSM.
REQ-005 a0, b0, a1, b1  input  1 each  requester input symbols (a,b).
REQ-006 fsm_y0, fsm_y1  input  1 each  outputs returned by the shared FSM.
REQ-007 fsm_a, fsm_b  output  1 each  symbol driven to the shared FSM.
REQ-008 fsm_rst  output  1  flush pulse to the shared FSM's reset input.
REQ-009 gnt0, gnt1  output  1 each  grant indicators; never both high.
REQ-010 rsp_y0, rsp_y1  output  1 each  forwarded fsm_y0/fsm_y1.
REQ-011 rsp_vld0, rsp_vld1  output  1 each  response valid for requester 0/1.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 States: IDLE, FLUSH, GRANT0, GRANT1; state, owner, last_owner and a 3-bit hold_cnt are registered.
REQ-014 IDLE: gnt0=gnt1=0, fsm_a=fsm_b=0, fsm_rst=0; on any req, select owner and go to FLUSH next cycle.
REQ-015 Owner selection: a single request wins; on simultaneous req0 and req1, the requester that is not last_owner wins.
REQ-016 FLUSH: lasts exactly one cycle, fsm_rst=1, gnt0=gnt1=0, fsm_a=fsm_b=0; always proceeds to GRANT<owner>.
REQ-017 GRANTx: gntx=1; fsm_a/fsm_b equal ax/bx combinationally in the same cycle; rsp_vldx=gntx; rsp_y0/rsp_y1 equal fsm_y0/fsm_y1 combinationally.
REQ-018 hold_cnt clears on entry to GRANTx, increments each GRANTx cycle, and saturates at MAX_HOLD-1.
REQ-019 In GRANTx, if reqx=0: set last_owner=x; go to FLUSH with the other owner if the other req=1, else go to IDLE.
REQ-020 In GRANTx, if reqx=1, the other req=1 and hold_cnt==MAX_HOLD-1: set last_owner=x and go to FLUSH with the other owner (forced rotation).
REQ-021 In GRANTx, if reqx=1 and the other req=0: remain in GRANTx indefinitely with hold_cnt saturated.
REQ-022 Requester inputs are ignored while the requester is not granted; fsm_a/fsm_b never carry the non-owner's symbols.
REQ-023 Only a request asserted at a state-evaluation edge is acted on; req pulses between edges are not remembered.

Reset
REQ-024 When reset=1 at a clock edge: state=IDLE, last_owner=1 (req0 wins the first tie), hold_cnt=0, owner=0.
REQ-025 While in reset: gnt0=gnt1=0, rsp_vld0=rsp_vld1=0, busy=0, fsm_a=fsm_b=0, fsm_rst=0.
REQ-026 Reset asserted mid-grant or mid-flush aborts immediately with no final flush pulse.

Configuration
REQ-027 Macro ARB_FLUSH_EN is defined: the FLUSH state is present and every ownership change (IDLE to grant, or switch) emits one fsm_rst cycle as in REQ-016.
REQ-028 Macro ARB_FLUSH_EN is undefined: FLUSH is removed; transitions that would enter FLUSH go directly to GRANT<owner>; fsm_rst is tied to 0. Grant latency from IDLE is then 1 cycle instead of 2.

Verification
REQ-029 Reset check: reset=1 with req0=req1=1 for 2 cycles -> gnt=00, busy=0, fsm_rst=0 throughout.
REQ-030 Single request: after reset, req0=1, a0=1, b0=0 -> FLUSH next cycle (fsm_rst=1), then gnt0=1, fsm_a=1, fsm_b=0, rsp_vld0=1; drop req0 -> IDLE next cycle.
REQ-031 Tie after reset: req0=req1=1 -> owner 0 first; with MAX_HOLD=4, gnt0 high exactly 4 cycles, then a FLUSH cycle, then gnt1=1.
REQ-032 Fair rotation: both requesters held high for 20 cycles -> grants alternate 0,1,0,1 with 4 grant cycles plus 1 flush cycle per turn; gnt0 and gnt1 never both high.
REQ-033 Mid-operation reset: reset=1 during the 2nd cycle of GRANT1 -> gnt1=0 and busy=0 at the next edge, no fsm_rst pulse; after release with req0=req1=1 -> req0 wins.
REQ-034 Build without ARB_FLUSH_EN: repeat REQ-030 -> gnt0=1 one cycle after req0 is sampled; fsm_rst stays 0 throughout.

Source files
------------

// File: rtl/fsm_input_arbiter.sv
// fsm_input_arbiter: two-requester arbiter for a shared 2-input FSM.
// Grants alternate fairly and a hold counter caps a turn at MAX_HOLD cycles
// while the other side waits.
// Build option: define ARB_FLUSH_EN to insert a one-cycle FLUSH (fsm_rst pulse)
// on every ownership change. When it is undefined, grants follow directly.
module fsm_input_arbiter #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic a0,
  input  logic b0,
  input  logic a1,
  input  logic b1,
  input  logic fsm_y0,
  input  logic fsm_y1,
  output logic fsm_a,
  output logic fsm_b,
  output logic fsm_rst,
  output logic gnt0,
  output logic gnt1,
  output logic rsp_y0,
  output logic rsp_y1,
  output logic rsp_vld0,
  output logic rsp_vld1,
  output logic busy
);

  if (MAX_HOLD < 1 || MAX_HOLD > 7) begin : g_bad_hold
    $error("fsm_input_arbiter: MAX_HOLD must be within 1..7");
  end

  localparam logic [2:0] HOLD_MAX = 3'(MAX_HOLD - 1);

  typedef enum logic [1:0] {IDLE, FLUSH, GRANT0, GRANT1} state_t;

  state_t     state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_q, last_d;
  logic [2:0] hold_q, hold_d;

  // The current owner's view of the request lines while in a grant state.
  logic cur, my_req, oth_req;
  assign cur     = (state_q == GRANT1);
  assign my_req  = cur ? req1 : req0;
  assign oth_req = cur ? req0 : req1;

  // Ownership hand-off request raised by the next-state logic.
  logic take, take_owner;

  // State, owner, last owner and hold counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      hold_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state logic: pick a new owner, rotate on hold expiry, release on drop.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    hold_d     = hold_q;
    take       = 1'b0;
    take_owner = owner_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          take       = 1'b1;
          // A tie goes to whoever did not own the FSM last.
          take_owner = (req0 && req1) ? ~last_q : req1;
        end
      end
`ifdef ARB_FLUSH_EN
      FLUSH: begin
        state_d = owner_q ? GRANT1 : GRANT0;
        hold_d  = 3'd0;
      end
`endif
      GRANT0, GRANT1: begin
        if (hold_q != HOLD_MAX) hold_d = hold_q + 3'd1;
        if (!my_req) begin
          last_d = cur;
          if (oth_req) begin
            take       = 1'b1;
            take_owner = ~cur;
          end else begin
            state_d = IDLE;
          end
        end else if (oth_req && hold_q == HOLD_MAX) begin
          last_d     = cur;
          take       = 1'b1;
          take_owner = ~cur;
        end
      end
      default: state_d = IDLE;
    endcase
    if (take) begin
      owner_d = take_owner;
`ifdef ARB_FLUSH_EN
      state_d = FLUSH;
`else
      state_d = take_owner ? GRANT1 : GRANT0;
      hold_d  = 3'd0;
`endif
    end
  end

  // Outputs are gated by reset so an asserted reset silences the bus at once.
  always_comb begin
    gnt0    = !reset && (state_q == GRANT0);
    gnt1    = !reset && (state_q == GRANT1);
    busy    = !reset && (state_q != IDLE);
`ifdef ARB_FLUSH_EN
    fsm_rst = !reset && (state_q == FLUSH);
`else
    fsm_rst = 1'b0;
`endif
    fsm_a    = 1'b0;
    fsm_b    = 1'b0;
    if (gnt0) begin
      fsm_a = a0;
      fsm_b = b0;
    end else if (gnt1) begin
      fsm_a = a1;
      fsm_b = b1;
    end
    rsp_vld0 = gnt0;
    rsp_vld1 = gnt1;
    rsp_y0   = fsm_y0;
    rsp_y1   = fsm_y1;
  end

endmodule
